// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the DataMemory interface.
// Turns CPU byte/half/word load/store requests into single-cycle memory accesses
// on DataMemory's active-low MemRead/MemWrite strobes. Loads are lane-extracted
// and sign/zero-extended. Sub-word stores are done as read-modify-write.
// All memory-side outputs come from registered state only, so they stay stable
// for a full CLK period.
module mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  Reset,
    // CPU side
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            size,
    input  logic                  sign_ext,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [31:0]           rdata,
    // DataMemory side
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [31:0]           WriteData,
    output logic                  MemRead,
    output logic                  MemWrite,
    input  logic [31:0]           DataOut
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RD     = 2'd1;
    localparam logic [1:0] RMW_RD = 2'd2;
    localparam logic [1:0] WR     = 2'd3;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [1:0]            state;
    logic [1:0]            stateNext;
    logic [ADDR_WIDTH-1:0] addrReg;
    logic [1:0]            laneReg;
    logic [1:0]            sizeReg;
    logic                  signExtReg;
    logic [15:0]           storeDataReg;
    logic [31:0]           writeBuf;
    logic [31:0]           rdataReg;
    logic                  doneReg;
    logic                  errReg;

    logic                  misaligned;
    logic                  accept;
    logic                  acceptOk;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] extractLoad(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  sz,
        input logic        sx
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SIZE_BYTE: res = {{24{sx & b[7]}}, b};
            SIZE_HALF: res = {{16{sx & h[15]}}, h};
            default:   res = word;
        endcase
        return res;
    endfunction

    // Overlay the latched byte/half onto the read word, other lanes untouched.
    function automatic logic [31:0] mergeStore(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [1:0]  sz,
        input logic [15:0] data
    );
        logic [31:0] res;
        res = word;
        if (sz == SIZE_BYTE) begin
            res[{lane, 3'b000} +: 8] = data[7:0];
        end else if (lane[1]) begin
            res[31:16] = data;
        end else begin
            res[15:0] = data;
        end
        return res;
    endfunction

    // Classify the incoming request; reserved size is treated as misaligned.
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: misaligned = 1'b0;
            SIZE_HALF: misaligned = addr[0];
            SIZE_WORD: misaligned = (addr[1:0] != 2'b00);
            default:   misaligned = 1'b1;
        endcase
        accept   = (state == IDLE) && req;
        acceptOk = accept && !misaligned;
    end

    // Next-state decode: every non-idle state lasts exactly one cycle.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (acceptOk) begin
                    if (!we) begin
                        stateNext = RD;
                    end else if (size == SIZE_WORD) begin
                        stateNext = WR;
                    end else begin
                        stateNext = RMW_RD;
                    end
                end
            end
            RD:      stateNext = IDLE;
            RMW_RD:  stateNext = WR;
            WR:      stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register; reset drops any in-flight access at once.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Request latches, captured only when a well-formed request is accepted.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            addrReg      <= '0;
            laneReg      <= 2'b00;
            sizeReg      <= SIZE_BYTE;
            signExtReg   <= 1'b0;
            storeDataReg <= 16'h0000;
        end else if (acceptOk) begin
            addrReg      <= {addr[ADDR_WIDTH-1:2], 2'b00};
            laneReg      <= addr[1:0];
            sizeReg      <= size;
            signExtReg   <= sign_ext;
            storeDataReg <= wdata[15:0];
        end
    end

    // Write buffer: full word straight from the CPU, or the RMW merge result.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            writeBuf <= 32'h0000_0000;
        end else if (acceptOk && we && (size == SIZE_WORD)) begin
            writeBuf <= wdata;
        end else if (state == RMW_RD) begin
            writeBuf <= mergeStore(DataOut, laneReg, sizeReg, storeDataReg);
        end
    end

    // Load result; only a completed RD updates it, so err leaves it untouched.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            rdataReg <= 32'h0000_0000;
        end else if (state == RD) begin
            rdataReg <= extractLoad(DataOut, laneReg, sizeReg, signExtReg);
        end
    end

    // Completion pulses: one cycle after the last access cycle, or right after
    // a rejected request.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            doneReg <= 1'b0;
            errReg  <= 1'b0;
        end else begin
            doneReg <= (state == RD) || (state == WR) || (accept && misaligned);
            errReg  <= accept && misaligned;
        end
    end

    // Output decode from registered state only; RD/RMW_RD and WR are exclusive
    // states, so the two strobes can never be low together.
    always_comb begin
        busy      = (state != IDLE);
        MemRead   = !((state == RD) || (state == RMW_RD));
        MemWrite  = !(state == WR);
        Address   = addrReg;
        WriteData = writeBuf;
        rdata     = rdataReg;
        done      = doneReg;
        err       = errReg;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural DataMemory model
// (falling-edge write, combinational read, high-Z when not reading).
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sizeIn = 2'b00;
    logic        signExt = 1'b0;
    logic [31:0] addrIn = 32'h0;
    logic [31:0] wdataIn = 32'h0;
    logic        busy, done, err;
    logic [31:0] rdata;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemRead, MemWrite;
    wire  [31:0] DataOut;

    logic [31:0] mem [0:15] = '{default: 32'h0};

    int nAsserts = 0;
    int nFails = 0;
    int cyc, nRd, nWr, bothLow;
    logic [31:0] wdSeen, addrSeen;
    logic errSeen;

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .req      (req),
        .we       (we),
        .size     (sizeIn),
        .sign_ext (signExt),
        .addr     (addrIn),
        .wdata    (wdataIn),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .rdata    (rdata),
        .Address  (Address),
        .WriteData(WriteData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .DataOut  (DataOut)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (MemWrite === 1'b0) mem[Address[5:2]] <= WriteData;
    end

    assign DataOut = (MemRead === 1'b0) ? mem[Address[5:2]] : 32'hzzzz_zzzz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it until done, recording strobe activity.
    task automatic runOp(input logic w, input logic [1:0] sz, input logic sx,
                         input logic [31:0] a, input logic [31:0] d);
        we = w; sizeIn = sz; signExt = sx; addrIn = a; wdataIn = d; req = 1'b1;
        cyc = 0; nRd = 0; nWr = 0; bothLow = 0; wdSeen = 32'h0; addrSeen = 32'h0;
        do begin
            @(posedge CLK); #1;
            req = 1'b0;
            cyc++;
            if (MemRead === 1'b0) nRd++;
            if (MemWrite === 1'b0) begin
                nWr++;
                wdSeen = WriteData;
                addrSeen = Address;
            end
            if (MemRead === 1'b0 && MemWrite === 1'b0) bothLow++;
        end while (done !== 1'b1 && cyc < 8);
        errSeen = err;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        repeat (2) @(posedge CLK);
        #1;
        check("rst_MemRead", MemRead, 1);
        check("rst_MemWrite", MemWrite, 1);
        check("rst_Address", Address, 0);
        check("rst_WriteData", WriteData, 0);
        check("rst_rdata", rdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        Reset = 1'b0;
        @(posedge CLK); #1;

        // Word store 8
        runOp(1, 2'b10, 0, 32'd8, 32'h1122_3344);
        check("sw8_latency", cyc, 2);
        check("sw8_nWr", nWr, 1);
        check("sw8_nRd", nRd, 0);
        check("sw8_addr", addrSeen, 32'd8);
        check("sw8_data", wdSeen, 32'h1122_3344);
        check("sw8_err", errSeen, 0);
        check("sw8_bothLow", bothLow, 0);
        runOp(0, 2'b10, 0, 32'd8, 32'h0);
        check("lw8_latency", cyc, 2);
        check("lw8_nRd", nRd, 1);
        check("lw8_rdata", rdata, 32'h1122_3344);

        // Byte store 9 (read-modify-write)
        runOp(1, 2'b00, 0, 32'd9, 32'h0000_00AA);
        check("sb9_latency", cyc, 3);
        check("sb9_nRd", nRd, 1);
        check("sb9_nWr", nWr, 1);
        check("sb9_data", wdSeen, 32'h1122_AA44);
        check("sb9_bothLow", bothLow, 0);
        runOp(0, 2'b10, 0, 32'd8, 32'h0);
        check("lw8b_rdata", rdata, 32'h1122_AA44);

        // Sub-word loads
        runOp(0, 2'b00, 1, 32'd9, 32'h0);
        check("lb9_sx", rdata, 32'hFFFF_FFAA);
        check("lb9_lat", cyc, 2);
        runOp(0, 2'b00, 0, 32'd9, 32'h0);
        check("lb9_zx", rdata, 32'h0000_00AA);
        runOp(0, 2'b01, 1, 32'd10, 32'h0);
        check("lh10_sx", rdata, 32'h0000_1122);

        // Half store 10, then extended reads
        runOp(1, 2'b01, 0, 32'd10, 32'h0000_8001);
        check("sh10_latency", cyc, 3);
        check("sh10_data", wdSeen, 32'h8001_AA44);
        runOp(0, 2'b01, 1, 32'd10, 32'h0);
        check("lh10b_sx", rdata, 32'hFFFF_8001);
        runOp(0, 2'b01, 0, 32'd10, 32'h0);
        check("lh10b_zx", rdata, 32'h0000_8001);
        runOp(0, 2'b00, 1, 32'd11, 32'h0);
        check("lb11_sx", rdata, 32'hFFFF_FF80);
        runOp(0, 2'b00, 0, 32'd8, 32'h0);
        check("lb8_zx", rdata, 32'h0000_0044);

        // Misaligned and reserved-size requests
        runOp(0, 2'b01, 1, 32'd11, 32'h0);
        check("mis_lh11_latency", cyc, 1);
        check("mis_lh11_err", errSeen, 1);
        check("mis_lh11_strobes", nRd + nWr, 0);
        check("mis_lh11_rdata", rdata, 32'h0000_0044);
        @(posedge CLK); #1;
        check("mis_err_pulse", err, 0);
        runOp(1, 2'b10, 0, 32'd14, 32'hCAFE_F00D);
        check("mis_sw14_latency", cyc, 1);
        check("mis_sw14_err", errSeen, 1);
        check("mis_sw14_nWr", nWr, 0);
        runOp(1, 2'b11, 0, 32'd0, 32'h0);
        check("mis_size11_err", errSeen, 1);
        check("mis_size11_strobes", nRd + nWr, 0);
        runOp(0, 2'b10, 0, 32'd12, 32'h0);
        check("lw12_untouched", rdata, 32'h0);
        check("lw12_err", errSeen, 0);

        // req while busy is ignored
        we = 1; sizeIn = 2'b00; addrIn = 32'd8; wdataIn = 32'h77; req = 1;
        @(posedge CLK); #1;
        check("ign_rmw_rd", MemRead, 0);
        sizeIn = 2'b10; addrIn = 32'd0; wdataIn = 32'h55;
        @(posedge CLK); #1;
        check("ign_wr", MemWrite, 0);
        check("ign_wr_data", WriteData, 32'h8001_AA77);
        req = 0;
        @(posedge CLK); #1;
        check("ign_done", done, 1);
        @(posedge CLK); #1;
        check("ign_busy", busy, 0);
        check("ign_no_write", MemWrite, 1);
        runOp(0, 2'b10, 0, 32'd0, 32'h0);
        check("ign_lw0", rdata, 32'h0);

        // req held through the done cycle: back-to-back word stores 8 and 12
        we = 1; sizeIn = 2'b10; addrIn = 32'd8; wdataIn = 32'd8; req = 1;
        @(posedge CLK); #1;
        check("b2b_wr1", MemWrite, 0);
        addrIn = 32'd12; wdataIn = 32'd12;
        @(posedge CLK); #1;
        check("b2b_done1", done, 1);
        check("b2b_idle1", busy, 0);
        @(posedge CLK); #1;
        check("b2b_accept2", busy, 1);
        check("b2b_addr2", Address, 32'd12);
        check("b2b_data2", WriteData, 32'd12);
        req = 0;
        @(posedge CLK); #1;
        check("b2b_done2", done, 1);
        runOp(0, 2'b10, 0, 32'd8, 32'h0);
        check("b2b_lw8", rdata, 32'd8);
        runOp(0, 2'b10, 0, 32'd12, 32'h0);
        check("b2b_lw12", rdata, 32'd12);

        // Reset in the middle of WR
        we = 1; sizeIn = 2'b10; addrIn = 32'd12; wdataIn = 32'hDEAD_BEEF; req = 1;
        @(posedge CLK); #1;
        req = 0;
        check("rwr_in_wr", MemWrite, 0);
        Reset = 1;
        #1;
        check("rwr_MemWrite", MemWrite, 1);
        check("rwr_MemRead", MemRead, 1);
        check("rwr_Address", Address, 0);
        check("rwr_WriteData", WriteData, 0);
        check("rwr_rdata", rdata, 0);
        check("rwr_busy", busy, 0);
        @(posedge CLK); #1;
        Reset = 0;
        @(posedge CLK); #1;
        check("rwr_done", done, 0);
        runOp(0, 2'b10, 0, 32'd12, 32'h0);
        check("rwr_lw12", rdata, 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. Sits between the CPU datapath's load/store stage and DataMemory.
- Accepts byte, halfword and word load/store requests from the CPU and drives DataMemory's active-low MemRead/MemWrite strobes, word-aligned Address and WriteData.
- Performs sign or zero extension on loads. Implements sub-word stores as read-modify-write.
- Provides a req/busy/done handshake toward the CPU.

Parameters:
- ADDR_WIDTH, 32, width of CPU byte address and memory Address bus.

Ports:
- CLK  in  1  system clock. DataMemory writes on the CLK falling edge.
- Reset  in  1  asynchronous, active-high reset.
- req  in  1  CPU request strobe. Sampled on CLK rising edge in IDLE only.
- we  in  1  1 = store, 0 = load.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved (treated as misaligned/error).
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_WIDTH  CPU byte address.
- wdata  in  32  store data, right-justified.
- busy  out  1  high whenever state != IDLE.
- done  out  1  registered one-cycle completion pulse.
- err  out  1  registered one-cycle pulse, coincident with done, for misaligned or reserved-size requests.
- rdata  out  32  extended load result. Valid from the done cycle, held until the next load completes.
- Address  out  ADDR_WIDTH  to DataMemory: {addr[ADDR_WIDTH-1:2], 2'b00}.
- WriteData  out  32  to DataMemory: merged store word.
- MemRead  out  1  to DataMemory: 0 = read, 1 = DataOut high-Z.
- MemWrite  out  1  to DataMemory: 0 = write, 1 = no operation.
- DataOut  in  32  from DataMemory: combinational read data.

Behaviour:
- Reset (asynchronous, immediate):
  - state = IDLE; MemRead = 1, MemWrite = 1.
  - Address = 0, WriteData = 0, rdata = 0, done = 0, err = 0.
  - Any in-flight access is aborted. If Reset asserts during WR, MemWrite rises at once and no write may occur on the following falling edge.
- Byte lanes are little-endian: byte k is DataOut[8k+7:8k], with k = addr[1:0].
- Misaligned: half with addr[0] = 1, word with addr[1:0] != 0, or size = 11.
- States:
  - IDLE: busy = 0, strobes = 1. On req:
    - misaligned -> stay in IDLE, pulse done = 1 and err = 1 in the next cycle, no memory access;
    - else latch addr/size/sign_ext/wdata/we;
    - load -> RD; store word -> WR; store byte/half -> RMW_RD.
  - RD (1 cycle): MemRead = 0, Address driven. At the rising edge ending RD, capture DataOut, extract the lane, extend, and register into rdata. done = 1 in the next cycle -> IDLE.
  - RMW_RD (1 cycle): MemRead = 0. At the end of the cycle, merge the latched byte/half into the captured word (other lanes unchanged) into the write buffer -> WR.
  - WR (1 cycle): MemWrite = 0, MemRead = 1, WriteData = buffer. The memory write occurs on this cycle's falling edge. Next cycle done = 1 -> IDLE.
- MemRead and MemWrite are never 0 simultaneously.
- Strobes, Address and WriteData are decoded from registered state/latches only; they are stable across a full CLK period.
- Latency, counted from the accept edge at N:
  - load: done at N+2;
  - word store: done at N+2;
  - sub-word store: done at N+3;
  - misaligned: done + err at N+1.
- The done cycle is IDLE, so a new req in the done cycle is accepted: back-to-back operation, one idle-free turnaround.
- req while busy = 1 is ignored, not queued. Inputs may change freely while busy.
- Store data: byte uses wdata[7:0]; half uses wdata[15:0]. Loads never modify rdata on err.

Test Plan:
- Reset, then word store addr = 8, wdata = 0x11223344:
  - MemWrite = 0 for exactly one cycle with Address = 8, WriteData = 0x11223344;
  - done at N+2; a following word load at 8 returns rdata = 0x11223344.
- Byte store addr = 9, wdata = 0x000000AA after the above:
  - RMW_RD cycle with MemRead = 0, then WR with WriteData = 0x1122AA44;
  - done at N+3; word load at 8 returns 0x1122AA44.
- Loads from the word at 8:
  - byte addr 9, sign_ext = 1 -> 0xFFFFFFAA;
  - byte addr 9, sign_ext = 0 -> 0x000000AA;
  - half addr 10, sign_ext = 1 -> 0x00001122;
  - half store addr 10, wdata = 0x8001, then signed half load at 10 -> 0xFFFF8001.
- Misaligned requests:
  - half load addr 11 -> done = err = 1 at N+1, no strobe activity, rdata unchanged;
  - word store addr 14 -> same, memory word at 12 unchanged.
- Handshake:
  - a req pulse during busy is ignored;
  - a req held through the done cycle is accepted at that edge;
  - two back-to-back word stores (8 then 12, values 8 and 12) complete, and loads return 8 and 12.
- Reset asserted mid-WR of a word store to addr 12, wdata = 0xDEADBEEF:
  - MemWrite = 1 immediately and all outputs take their reset values;
  - a subsequent load at 12 returns the prior value.
